// File: rtl/lfsr_checker_if.sv
// -----------------------------------------------------------------------------
// lfsr_checker_if
// Groups the sample stream and status signals of the LFSR checker.
//   enable      : rx_bits carries a valid sample this cycle      (master -> slave)
//   rx_bits     : received LFSR word, WIDTH bits                 (master -> slave)
//   clr_errors  : synchronous clear of error_count               (master -> slave)
//   locked      : checker is in LOCKED                           (slave -> master)
//   error_pulse : one-cycle pulse per mismatch counted in LOCKED (slave -> master)
//   error_count : saturating mismatch count, CNT_WIDTH bits      (slave -> master)
//   stuck       : all-zero word seen (only with stuck detection) (slave -> master)
// -----------------------------------------------------------------------------
interface lfsr_checker_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 enable;
  logic [WIDTH-1:0]     rx_bits;
  logic                 clr_errors;
  logic                 locked;
  logic                 error_pulse;
  logic [CNT_WIDTH-1:0] error_count;
  logic                 stuck;

  modport master (
    output enable, rx_bits, clr_errors,
    input  locked, error_pulse, error_count, stuck
  );

  modport slave (
    input  enable, rx_bits, clr_errors,
    output locked, error_pulse, error_count, stuck
  );
endinterface

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
// Synchronises to an 8-bit Fibonacci LFSR stream (taps 7,5,4,3), then
// flywheels the expected word and counts mismatches.
//   HUNT   : first valid sample seeds the expected word.
//   VERIFY : LOCK_COUNT consecutive matches are needed to lock; a mismatch
//            reseeds from the received word.
//   LOCKED : expected word advances on its own; each mismatch pulses
//            error_pulse and bumps error_count (saturating); LOSS_COUNT
//            consecutive mismatches drop back to HUNT.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lfsr_checker_if.slave (enable, rx_bits, clr_errors in;
//           locked, error_pulse, error_count, stuck out)
// Parameters: WIDTH (8 only), LOCK_COUNT (1-15), LOSS_COUNT (1-15), CNT_WIDTH.
// Optional feature macro: LFSR_CHECKER_STUCK_DET_EN -- an all-zero word with
// enable sets sticky 'stuck', forces HUNT and does not seed the expected word.
// Without it, 'stuck' is tied 0 and zero words are ordinary data.
// -----------------------------------------------------------------------------
module lfsr_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_WIDTH  = 16
) (
  input logic           clk,
  input logic           rst_n,
  lfsr_checker_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [3:0]           LOCK_LIM = 4'(LOCK_COUNT);
  localparam logic [3:0]           LOSS_LIM = 4'(LOSS_COUNT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic [3:0]           match_cnt_q, match_cnt_d;
  logic [3:0]           miss_cnt_q, miss_cnt_d;
  logic                 locked_q, locked_d;
  logic                 error_pulse_q, error_pulse_d;
  logic [CNT_WIDTH-1:0] error_count_q, error_count_d;
  logic                 stuck_q, stuck_d;

  logic rx_match;
  logic zero_word;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  assign rx_match = (bus.rx_bits == exp_q);

`ifdef LFSR_CHECKER_STUCK_DET_EN
  // An all-zero word is the LFSR lock-up state; treat it as a line fault.
  assign zero_word = bus.enable && (bus.rx_bits == '0);
`else
  assign zero_word = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register (holds every register of the block)
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments here so all registers update together on
  // the edge; blocking ones would let later lines see half-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      exp_q         <= '0;
      match_cnt_q   <= '0;
      miss_cnt_q    <= '0;
      locked_q      <= 1'b0;
      error_pulse_q <= 1'b0;
      error_count_q <= '0;
      stuck_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      match_cnt_q   <= match_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      locked_q      <= locked_d;
      error_pulse_q <= error_pulse_d;
      error_count_q <= error_count_d;
      stuck_q       <= stuck_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (bus.enable) begin
      if (zero_word) begin
        state_d = HUNT;
      end else begin
        unique case (state_q)
          HUNT:   state_d = VERIFY;
          VERIFY: if (rx_match && (match_cnt_q + 4'd1 == LOCK_LIM)) state_d = LOCKED;
          LOCKED: if (!rx_match && (miss_cnt_q + 4'd1 == LOSS_LIM)) state_d = HUNT;
          default: state_d = HUNT;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    exp_d         = exp_q;
    match_cnt_d   = match_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    error_pulse_d = 1'b0;
    error_count_d = error_count_q;
    stuck_d       = stuck_q;

    if (bus.enable) begin
      if (zero_word) begin
        stuck_d     = 1'b1;
        match_cnt_d = '0;
        miss_cnt_d  = '0;
      end else begin
        unique case (state_q)
          HUNT: begin
            exp_d       = lfsr_next(bus.rx_bits);
            match_cnt_d = '0;
            miss_cnt_d  = '0;
          end
          VERIFY: begin
            // On a match next(rx) equals next(exp); on a mismatch this reseeds.
            exp_d      = lfsr_next(bus.rx_bits);
            miss_cnt_d = '0;
            if (rx_match && state_d != LOCKED) match_cnt_d = match_cnt_q + 4'd1;
            else                               match_cnt_d = '0;
          end
          LOCKED: begin
            // Flywheel: a corrupted word must not disturb the local sequence.
            exp_d = lfsr_next(exp_q);
            if (rx_match) begin
              miss_cnt_d = '0;
            end else begin
              error_pulse_d = 1'b1;
              if (error_count_q != CNT_MAX) error_count_d = error_count_q + CNT_WIDTH'(1);
              // Cleared when dropping to HUNT so the 4-bit counter never wraps.
              miss_cnt_d = (state_d == HUNT) ? 4'd0 : miss_cnt_q + 4'd1;
            end
          end
          default: begin
            exp_d       = '0;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
          end
        endcase
      end
    end

    // Clear wins over a coincident increment; the pulse still reports it.
    if (bus.clr_errors) error_count_d = '0;

    locked_d = (state_d == LOCKED);
  end

  assign bus.locked      = locked_q;
  assign bus.error_pulse = error_pulse_q;
  assign bus.error_count = error_count_q;
  assign bus.stuck       = stuck_q;

endmodule
